// File: rtl/reflet_bus_pkg.sv
// reflet_bus_pkg: shared FSM states and sizing helpers for the reflet bus fabric
package reflet_bus_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP, ERR} state_t;
  localparam int wait_w = 8;
  function automatic int cnt_width(input int max_wait);
    return (max_wait < 1) ? 1 : $clog2(max_wait + 1);
  endfunction
  function automatic int idx_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/reflet_bus_decode.sv
// reflet_bus_decode: combinational priority region matcher, lowest matching index wins
module reflet_bus_decode
  import reflet_bus_pkg::*;
#(
  parameter int wordsize = 16,
  parameter int region_count = 3,
  parameter int idx_w = idx_width(region_count)
) (
  input  logic [wordsize-1:0]              addr,
  input  logic [region_count*wordsize-1:0] region_base,
  input  logic [region_count*wordsize-1:0] region_mask,
  output logic                             hit,
  output logic [idx_w-1:0]                 index
);
  always_comb begin
    hit = 1'b0;
    index = '0;
    for (int i = region_count - 1; i >= 0; i--) begin
      if ((addr & region_mask[i*wordsize +: wordsize]) ==
          (region_base[i*wordsize +: wordsize] & region_mask[i*wordsize +: wordsize])) begin
        hit = 1'b1;
        index = idx_w'(i);
      end
    end
  end
endmodule

// File: rtl/reflet_bus_fabric.sv
// reflet_bus_fabric: region-mapped CPU-to-slave bus with wait states and bus errors (REFLET_BUS_ERR_CAPTURE_EN adds err_addr/err_flag)
module reflet_bus_fabric
  import reflet_bus_pkg::*;
#(
  parameter int wordsize = 16,
  parameter int region_count = 3,
  parameter logic [region_count*wordsize-1:0] region_base = {16'h0000, 16'h8000, 16'hFF00},
  parameter logic [region_count*wordsize-1:0] region_mask = {16'h8000, 16'h8000, 16'hFF00},
  parameter logic [region_count*wait_w-1:0]   region_wait = {8'd2, 8'd0, 8'd1},
  parameter int max_wait = 3
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             cpu_req,
  input  logic [wordsize-1:0]              cpu_addr,
  input  logic [wordsize-1:0]              cpu_wdata,
  input  logic                             cpu_write_en,
  output logic                             cpu_ready,
  output logic [wordsize-1:0]              cpu_rdata,
  output logic                             bus_err,
  output logic [region_count-1:0]          slv_en,
  output logic [wordsize-1:0]              slv_addr,
  output logic [wordsize-1:0]              slv_wdata,
  output logic                             slv_write_en,
  input  logic [region_count*wordsize-1:0] slv_rdata
`ifdef REFLET_BUS_ERR_CAPTURE_EN
  ,
  output logic [wordsize-1:0]              err_addr,
  output logic                             err_flag
`endif
);
  localparam int cw = cnt_width(max_wait);
  localparam int iw = idx_width(region_count);
  state_t state_q, state_d;
  logic [wordsize-1:0] addr_q, addr_d, wdata_q, wdata_d;
  logic we_q, we_d, hit;
  logic [iw-1:0] sel_q, sel_d, idx;
  logic [cw-1:0] cnt_q, cnt_d;
  logic [wait_w-1:0] wait_sel;
  reflet_bus_decode #(.wordsize(wordsize), .region_count(region_count), .idx_w(iw)) u_decode (
    .addr(cpu_addr),
    .region_base(region_base),
    .region_mask(region_mask),
    .hit(hit),
    .index(idx)
  );
  assign wait_sel = region_wait[sel_q*wait_w +: wait_w];
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    we_d = we_q;
    sel_d = sel_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: if (cpu_req) begin
        addr_d = cpu_addr;
        if (hit) begin
          wdata_d = cpu_wdata;
          we_d = cpu_write_en;
          sel_d = idx;
          cnt_d = '0;
          state_d = ACCESS;
        end else state_d = ERR;
      end
      ACCESS: begin
        cnt_d = cnt_q + 1'b1;
        state_d = (wait_w'(cnt_q) == wait_sel) ? RESP : ACCESS;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      addr_q <= '0;
      wdata_q <= '0;
      we_q <= 1'b0;
      sel_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      we_q <= we_d;
      sel_q <= sel_d;
      cnt_q <= cnt_d;
    end
  end
  assign slv_en = (state_q == ACCESS || state_q == RESP) ? (region_count'(1) << sel_q) : '0;
  assign slv_addr = addr_q;
  assign slv_wdata = wdata_q;
  assign slv_write_en = state_q == ACCESS && cnt_q == '0 && we_q;
  assign cpu_ready = state_q == RESP || state_q == ERR;
  assign bus_err = state_q == ERR;
  assign cpu_rdata = (state_q == RESP && !we_q) ? slv_rdata[sel_q*wordsize +: wordsize] : '0;
`ifdef REFLET_BUS_ERR_CAPTURE_EN
  logic [wordsize-1:0] err_addr_q;
  logic err_flag_q;
  always_ff @(posedge clk) begin
    if (!reset) begin
      err_addr_q <= '0;
      err_flag_q <= 1'b0;
    end else if (state_q == ERR) begin
      err_addr_q <= addr_q;
      err_flag_q <= 1'b1;
    end
  end
  assign err_addr = err_addr_q;
  assign err_flag = err_flag_q;
`endif
endmodule

// File: tb/tb_reflet_bus_fabric.sv
// tb_reflet_bus_fabric: randomized self-checking bench against a region-map reference model
module tb_reflet_bus_fabric;
  localparam logic [15:0] base_m [3] = '{16'hFF00, 16'h8000, 16'h0000};
  localparam logic [15:0] mask_m [3] = '{16'hFF00, 16'h8000, 16'hC000};
  localparam int wait_m [3] = '{1, 0, 2};
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset, cpu_req, cpu_write_en, cpu_ready, bus_err, slv_write_en, init_mem;
  logic [15:0] cpu_addr, cpu_wdata, cpu_rdata, slv_addr, slv_wdata;
  logic [2:0] slv_en;
  logic [47:0] slv_rdata;
  logic [15:0] mem [3][16];
  logic [15:0] srd [3];
  logic [15:0] ref_mem [3][16];
  int errors = 0;
  int checks = 0;
`ifdef REFLET_BUS_ERR_CAPTURE_EN
  logic [15:0] err_addr;
  logic err_flag;
`endif
  reflet_bus_fabric #(
    .region_mask({16'hC000, 16'h8000, 16'hFF00})
  ) dut (
    .clk(clk),
    .reset(reset),
    .cpu_req(cpu_req),
    .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata),
    .cpu_write_en(cpu_write_en),
    .cpu_ready(cpu_ready),
    .cpu_rdata(cpu_rdata),
    .bus_err(bus_err),
    .slv_en(slv_en),
    .slv_addr(slv_addr),
    .slv_wdata(slv_wdata),
    .slv_write_en(slv_write_en),
    .slv_rdata(slv_rdata)
`ifdef REFLET_BUS_ERR_CAPTURE_EN
    ,
    .err_addr(err_addr),
    .err_flag(err_flag)
`endif
  );
  function automatic logic [15:0] seed(input int i, input int j);
    return 16'((i << 12) | (j << 8) | 'hC3);
  endfunction
  function automatic int ref_region(input logic [15:0] a);
    for (int i = 0; i < 3; i++)
      if ((a & mask_m[i]) == (base_m[i] & mask_m[i])) return i;
    return -1;
  endfunction
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (init_mem) begin
        for (int j = 0; j < 16; j++) mem[i][j] <= seed(i, j);
      end else if (slv_en[i] && slv_write_en) mem[i][slv_addr[3:0]] <= slv_wdata;
      srd[i] <= mem[i][slv_addr[3:0]];
    end
  end
  assign slv_rdata = {srd[2], srd[1], srd[0]};
  task automatic xfer(input logic [15:0] a, input logic [15:0] d, input logic w, input bit drop);
    int r, lat, strobes;
    bit got;
    logic [2:0] en_exp;
    logic [15:0] rd_exp;
    r = ref_region(a);
    lat = (r < 0) ? 1 : wait_m[r] + 2;
    en_exp = (r < 0) ? 3'b000 : 3'(1 << r);
    rd_exp = (r < 0 || w) ? 16'h0 : ref_mem[r][a[3:0]];
    cpu_req = 1'b1;
    cpu_addr = a;
    cpu_wdata = d;
    cpu_write_en = w;
    strobes = 0;
    got = 0;
    for (int k = 1; k <= lat + 3 && !got; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin
        cpu_addr = 16'($urandom);
        cpu_wdata = 16'($urandom);
        cpu_write_en = 1'($urandom);
        if (drop) cpu_req = 1'b0;
      end
      if (slv_write_en) begin
        strobes++;
        checks++;
        if (slv_wdata !== d || slv_addr !== a)
          begin errors++; $display("FAIL wr_strobe addr=%h wdata=%h expected addr=%h wdata=%h", slv_addr, slv_wdata, a, d); end
      end
      if (k <= lat) begin
        checks++;
        if (slv_en !== en_exp)
          begin errors++; $display("FAIL slv_en a=%h k=%0d got=%b expected=%b", a, k, slv_en, en_exp); end
      end
      if (cpu_ready) begin
        got = 1;
        cpu_req = 1'b0;
        checks++;
        if (k != lat) begin errors++; $display("FAIL latency a=%h got=%0d expected=%0d", a, k, lat); end
        checks++;
        if (bus_err !== (r < 0)) begin errors++; $display("FAIL bus_err a=%h got=%b expected=%b", a, bus_err, r < 0); end
        checks++;
        if (cpu_rdata !== rd_exp) begin errors++; $display("FAIL rdata a=%h got=%h expected=%h", a, cpu_rdata, rd_exp); end
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL timeout a=%h no cpu_ready within %0d cycles", a, lat + 3);
      cpu_req = 1'b0;
    end
    checks++;
    if (strobes != ((r >= 0 && w) ? 1 : 0))
      begin errors++; $display("FAIL strobe_count a=%h got=%0d expected=%0d", a, strobes, (r >= 0 && w) ? 1 : 0); end
    if (r >= 0 && w) ref_mem[r][a[3:0]] = d;
    @(posedge clk); #1;
    checks++;
    if (cpu_ready !== 1'b0 || slv_en !== 3'b000)
      begin errors++; $display("FAIL post_idle a=%h ready=%b slv_en=%b expected 0", a, cpu_ready, slv_en); end
`ifdef REFLET_BUS_ERR_CAPTURE_EN
    if (r < 0) begin
      checks++;
      if (err_flag !== 1'b1 || err_addr !== a)
        begin errors++; $display("FAIL err_capture flag=%b addr=%h expected flag=1 addr=%h", err_flag, err_addr, a); end
    end
`endif
  endtask
  task automatic test_reset;
    reset = 1'b0;
    init_mem = 1'b1;
    cpu_req = 1'b1;
    cpu_addr = 16'h8000;
    cpu_wdata = 16'h1234;
    cpu_write_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({cpu_ready, bus_err, slv_write_en, slv_en, cpu_rdata, slv_addr, slv_wdata} !== '0)
      begin errors++; $display("FAIL reset_outputs ready=%b err=%b we=%b en=%b rdata=%h addr=%h wdata=%h expected all 0",
        cpu_ready, bus_err, slv_write_en, slv_en, cpu_rdata, slv_addr, slv_wdata); end
`ifdef REFLET_BUS_ERR_CAPTURE_EN
    checks++;
    if (err_flag !== 1'b0 || err_addr !== 16'h0)
      begin errors++; $display("FAIL reset_err flag=%b addr=%h expected 0", err_flag, err_addr); end
`endif
    cpu_req = 1'b0;
    init_mem = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
  endtask
  task automatic test_read_region;
    xfer(16'h0123, 16'hBEEF, 1'b1, 0);
    xfer(16'h0123, 16'h0000, 1'b0, 0);
  endtask
  task automatic test_write_periph;
    xfer(16'hFF05, 16'h00A5, 1'b1, 0);
    xfer(16'hFF05, 16'h0000, 1'b0, 0);
  endtask
  task automatic test_unmapped;
    xfer(16'h4000, 16'h0000, 1'b0, 0);
    xfer(16'h7ABC, 16'h5555, 1'b1, 0);
  endtask
  task automatic test_back_to_back;
    int ks[$];
    logic [15:0] exp0, exp1;
    exp0 = ref_mem[1][0];
    exp1 = ref_mem[1][2];
    cpu_req = 1'b1;
    cpu_addr = 16'h8000;
    cpu_write_en = 1'b0;
    for (int k = 1; k <= 10 && ks.size() < 2; k++) begin
      @(posedge clk); #1;
      if (cpu_ready) begin
        ks.push_back(k);
        checks++;
        if (cpu_rdata !== (ks.size() == 1 ? exp0 : exp1))
          begin errors++; $display("FAIL b2b_rdata n=%0d got=%h expected=%h", ks.size(), cpu_rdata, ks.size() == 1 ? exp0 : exp1); end
        if (ks.size() == 1) cpu_addr = 16'h8002;
        else cpu_req = 1'b0;
      end
    end
    cpu_req = 1'b0;
    checks++;
    if (ks.size() != 2 || ks[0] != 2 || ks[1] != 5)
      begin errors++; $display("FAIL b2b_timing got %0d pulses first=%0d second=%0d expected 2 pulses at 2 and 5",
        ks.size(), ks.size() > 0 ? ks[0] : -1, ks.size() > 1 ? ks[1] : -1); end
    @(posedge clk); #1;
  endtask
  task automatic test_req_drop;
    xfer(16'h0123, 16'h0000, 1'b0, 1);
    xfer(16'hFF10, 16'h3C3C, 1'b1, 1);
    xfer(16'hFF10, 16'h0000, 1'b0, 1);
  endtask
  task automatic test_reset_mid_write;
    int bad;
    logic [15:0] d;
    d = 16'($urandom);
    cpu_req = 1'b1;
    cpu_addr = 16'h0005;
    cpu_wdata = d;
    cpu_write_en = 1'b1;
    @(posedge clk); #1;
    cpu_req = 1'b0;
    checks++;
    if (slv_write_en !== 1'b1) begin errors++; $display("FAIL rst_mid_strobe got=%b expected=1", slv_write_en); end
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({cpu_ready, bus_err, slv_write_en, slv_en, cpu_rdata, slv_addr, slv_wdata} !== '0)
      begin errors++; $display("FAIL rst_mid_outputs ready=%b en=%b we=%b addr=%h wdata=%h expected all 0",
        cpu_ready, slv_en, slv_write_en, slv_addr, slv_wdata); end
`ifdef REFLET_BUS_ERR_CAPTURE_EN
    checks++;
    if (err_flag !== 1'b0 || err_addr !== 16'h0)
      begin errors++; $display("FAIL rst_mid_err flag=%b addr=%h expected 0", err_flag, err_addr); end
`endif
    reset = 1'b1;
    ref_mem[2][5] = d;
    bad = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (slv_write_en || cpu_ready || slv_en != 3'b000) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL rst_mid_quiet got=%0d active cycles expected=0", bad); end
    xfer(16'h0005, 16'h0000, 1'b0, 0);
  endtask
  task automatic test_random;
    for (int n = 0; n < 40; n++) begin
      xfer(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
  endtask
  initial begin
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 16; j++) ref_mem[i][j] = seed(i, j);
    test_reset;
    test_read_region;
    test_write_periph;
    test_unmapped;
    test_back_to_back;
    test_req_drop;
    test_reset_mid_write;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
